// File: rtl/lut_sweep_eval.sv
// lut_sweep_eval: loadable N-input truth table with two run modes.
//   EVAL  : one registered beat f(x) for a captured operand x.
//   SWEEP : 2**N beats streaming (x, f(x)) for x = 0 .. 2**N-1, counting ones.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   tt_we, tt_wdata       truth-table write (accepted only while idle)
//   x, eval_req           single-evaluation operand and request
//   start                 full-sweep request (wins over eval_req)
//   out_valid/out_ready   result beat handshake; out_x, out_y, out_last payload
//   busy                  operation in progress
//   ones_cnt              ones seen in the last completed sweep
//   done                  one-cycle pulse after the final sweep handshake
module lut_sweep_eval #(
  parameter int unsigned               N       = 4,
  parameter logic [(2**N)-1:0]         INIT_TT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tt_we,
  input  logic [(2**N)-1:0]  tt_wdata,
  input  logic [N-1:0]       x,
  input  logic               eval_req,
  input  logic               start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_x,
  output logic               out_y,
  output logic               out_last,
  output logic               busy,
  output logic [N:0]         ones_cnt,
  output logic               done
);

  localparam int unsigned DEPTH  = 2**N;
  localparam int unsigned CW     = N + 1;
  localparam logic [N-1:0] LAST_X = N'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SWEEP = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [DEPTH-1:0]   tt_q,        tt_d;
  logic               out_valid_q, out_valid_d;
  logic [N-1:0]       out_x_q,     out_x_d;
  logic               out_y_q,     out_y_d;
  logic               out_last_q,  out_last_d;
  logic               busy_q,      busy_d;
  logic [CW-1:0]      ones_cnt_q,  ones_cnt_d;
  logic               done_q,      done_d;
  logic [N-1:0]       idx_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tt_q        <= INIT_TT;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      ones_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      ones_cnt_q  <= ones_cnt_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    ones_cnt_d  = ones_cnt_q;
    done_d      = 1'b0;
    idx_nxt     = out_x_q + N'(1);

    case (state_q)
      IDLE: begin
        // A same-cycle write is visible to the operation launched this edge.
        if (tt_we) begin
          tt_d = tt_wdata;
        end
        if (start) begin
          state_d     = SWEEP;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          out_x_d     = '0;
          out_y_d     = tt_d[0];
          out_last_d  = 1'b0;
          ones_cnt_d  = '0;
        end else if (eval_req) begin
          state_d     = EVAL;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          out_x_d     = x;
          out_y_d     = tt_d[x];
          out_last_d  = 1'b1;
        end
      end

      EVAL: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          out_x_d     = '0;
          out_y_d     = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      SWEEP: begin
        if (out_ready) begin
          ones_cnt_d = ones_cnt_q + CW'(out_y_q);
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            out_x_d     = '0;
            out_y_d     = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            // out_x doubles as the sweep index.
            out_x_d    = idx_nxt;
            out_y_d    = tt_q[idx_nxt];
            out_last_d = (idx_nxt == LAST_X);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign ones_cnt  = ones_cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Bench for lut_sweep_eval: an N=4 and an N=3 instance driven by directed and
// randomized steps, checked against a truth-table model held in the bench.
module tb_lut_sweep_eval;

  localparam logic [15:0] INIT4 = 16'h0F0F;
  localparam logic [7:0]  INIT3 = 8'h5A;

  logic clk;
  logic rst_n;
  logic out_ready;

  // N=4 instance
  logic        tt_we4, eval_req4, start4;
  logic [15:0] tt_wdata4;
  logic [3:0]  x4;
  logic        v4, y4, last4, busy4, done4;
  logic [3:0]  ox4;
  logic [4:0]  ones4;

  // N=3 instance
  logic        tt_we3, eval_req3, start3;
  logic [7:0]  tt_wdata3;
  logic [2:0]  x3;
  logic        v3, y3, last3, busy3, done3;
  logic [2:0]  ox3;
  logic [3:0]  ones3;

  lut_sweep_eval #(.N(4), .INIT_TT(INIT4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tt_we(tt_we4), .tt_wdata(tt_wdata4), .x(x4),
    .eval_req(eval_req4), .start(start4), .out_valid(v4), .out_ready(out_ready),
    .out_x(ox4), .out_y(y4), .out_last(last4), .busy(busy4), .ones_cnt(ones4),
    .done(done4)
  );

  lut_sweep_eval #(.N(3), .INIT_TT(INIT3)) dut3 (
    .clk(clk), .rst_n(rst_n), .tt_we(tt_we3), .tt_wdata(tt_wdata3), .x(x3),
    .eval_req(eval_req3), .start(start3), .out_valid(v3), .out_ready(out_ready),
    .out_x(ox3), .out_y(y3), .out_last(last3), .busy(busy3), .ones_cnt(ones3),
    .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux so one sweep routine serves both instances.
  logic       use3;
  logic       o_valid, o_y, o_last, o_busy, o_done;
  logic [7:0] o_x, o_ones;
  always_comb begin
    o_valid = use3 ? v3    : v4;
    o_y     = use3 ? y3    : y4;
    o_last  = use3 ? last3 : last4;
    o_busy  = use3 ? busy3 : busy4;
    o_done  = use3 ? done3 : done4;
    o_x     = use3 ? {5'b0, ox3}   : {4'b0, ox4};
    o_ones  = use3 ? {4'b0, ones3} : {3'b0, ones4};
  end

  int checks = 0;
  int errors = 0;

  // Reference model: current tables and last completed sweep counts.
  logic [15:0] tt_m4;
  logic [7:0]  tt_m3;
  int          ones_m4;
  int          ones_m3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep. stall_at/stall_len hold out_ready low at one index; rnd adds
  // random back-pressure; we_at raises tt_we mid-sweep (must be ignored).
  task automatic sweep(input bit s3, input logic [15:0] tt, input bit load,
                       input bit with_eval, input int stall_at, input int stall_len,
                       input bit rnd, input int we_at);
    int n, depth, idx, cyc, stalls, stalled, ones_exp;
    bit fin, rdy;
    logic [15:0] ttm;
    n = s3 ? 3 : 4;
    depth = 1 << n;
    idx = 0; cyc = 0; stalls = 0; stalled = 0; fin = 1'b0;
    use3 = s3;
    @(negedge clk);
    if (load) begin
      if (s3) begin tt_we3 = 1'b1; tt_wdata3 = tt[7:0]; tt_m3 = tt[7:0]; end
      else    begin tt_we4 = 1'b1; tt_wdata4 = tt;      tt_m4 = tt;      end
    end
    if (s3) start3 = 1'b1; else start4 = 1'b1;
    if (with_eval) begin eval_req4 = 1'b1; x4 = 4'($urandom_range(0, 15)); end
    ttm = s3 ? {8'h00, tt_m3} : tt_m4;
    ones_exp = s3 ? $countones(tt_m3) : $countones(tt_m4);
    @(negedge clk);
    tt_we3 = 1'b0; tt_we4 = 1'b0; start3 = 1'b0; start4 = 1'b0; eval_req4 = 1'b0;
    cyc = 1;
    while (!fin && cyc < 300) begin
      chk("beat_valid", o_valid, 1);
      chk("beat_busy", o_busy, 1);
      chk("beat_x", o_x, idx);
      chk("beat_y", o_y, ttm[idx]);
      chk("beat_last", o_last, (idx == depth - 1) ? 1 : 0);
      chk("beat_done_low", o_done, 0);
      if (!s3 && idx == we_at) begin tt_we4 = 1'b1; tt_wdata4 = ~ttm; end
      else tt_we4 = 1'b0;
      if (idx == stall_at && stalled < stall_len) begin
        rdy = 1'b0; stalled++;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      if (rdy) begin
        if (idx == depth - 1) fin = 1'b1; else idx++;
      end else begin
        stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    tt_we4 = 1'b0;
    out_ready = 1'b1;
    if (!fin) chk("sweep_timeout", 0, 1);
    chk("done_high", o_done, 1);
    chk("done_cycle", cyc, depth + 1 + stalls);
    chk("done_busy_low", o_busy, 0);
    chk("done_valid_low", o_valid, 0);
    chk("ones_cnt", o_ones, ones_exp);
    if (s3) ones_m3 = ones_exp; else ones_m4 = ones_exp;
    @(negedge clk);
    chk("done_pulse_end", o_done, 0);
    chk("idle_after_sweep", o_valid, 0);
    chk("ones_held", o_ones, ones_exp);
  endtask

  // Single evaluation on the N=4 instance with `hold` stall cycles.
  task automatic eval4(input logic [3:0] xv, input bit load, input logic [15:0] tt,
                       input int hold);
    use3 = 1'b0;
    @(negedge clk);
    if (load) begin tt_we4 = 1'b1; tt_wdata4 = tt; tt_m4 = tt; end
    eval_req4 = 1'b1;
    x4 = xv;
    out_ready = 1'b0;
    @(negedge clk);
    tt_we4 = 1'b0; eval_req4 = 1'b0;
    x4 = ~xv;
    for (int h = 0; h <= hold; h++) begin
      chk("eval_valid", o_valid, 1);
      chk("eval_x", o_x, xv);
      chk("eval_y", o_y, tt_m4[xv]);
      chk("eval_last", o_last, 1);
      chk("eval_busy", o_busy, 1);
      chk("eval_no_done", o_done, 0);
      chk("eval_ones_kept", o_ones, ones_m4);
      out_ready = (h == hold);
      @(negedge clk);
    end
    chk("eval_back_idle", o_valid, 0);
    chk("eval_busy_low", o_busy, 0);
    chk("eval_no_done_after", o_done, 0);
    out_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid4"}, v4, 0);   chk({tag, "_x4"}, ox4, 0);
    chk({tag, "_y4"}, y4, 0);       chk({tag, "_last4"}, last4, 0);
    chk({tag, "_busy4"}, busy4, 0); chk({tag, "_ones4"}, ones4, 0);
    chk({tag, "_done4"}, done4, 0);
    chk({tag, "_valid3"}, v3, 0);   chk({tag, "_busy3"}, busy3, 0);
    chk({tag, "_ones3"}, ones3, 0); chk({tag, "_done3"}, done3, 0);
  endtask

  initial begin
    int guard;
    logic [15:0] rt;
    rst_n = 1'b1; out_ready = 1'b1; use3 = 1'b0;
    tt_we4 = 1'b0; tt_wdata4 = '0; x4 = '0; eval_req4 = 1'b0; start4 = 1'b0;
    tt_we3 = 1'b0; tt_wdata3 = '0; x3 = '0; eval_req3 = 1'b0; start3 = 1'b0;
    tt_m4 = INIT4; tt_m3 = INIT3; ones_m4 = 0; ones_m3 = 0;

    // Power-on reset
    #3 rst_n = 1'b0;
    #2 chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Reset table visible through a sweep without loading
    sweep(1'b0, 16'h0, 1'b0, 1'b0, -1, 0, 1'b0, -1);

    // Directed sweep 8001, no back-pressure
    sweep(1'b0, 16'h8001, 1'b1, 1'b0, -1, 0, 1'b0, -1);
    chk("ones_8001", ones_m4, 2);
    // Same sweep, 3-cycle stall at x=5
    sweep(1'b0, 16'h8001, 1'b0, 1'b0, 5, 3, 1'b0, -1);

    // Single evaluation: AAAA, x=7 -> 1; ones_cnt kept
    eval4(4'd7, 1'b1, 16'hAAAA, 2);
    chk("ones_after_eval", ones4, 2);

    // Table frozen during sweep, then start+eval_req together runs a sweep
    sweep(1'b0, 16'h0000, 1'b1, 1'b0, -1, 0, 1'b0, 4);
    sweep(1'b0, 16'h0000, 1'b0, 1'b1, -1, 0, 1'b0, -1);
    chk("ones_frozen", ones4, 0);

    // Asynchronous reset mid-sweep at beat 8
    use3 = 1'b0;
    @(negedge clk);
    tt_we4 = 1'b1; tt_wdata4 = 16'hFFFF; tt_m4 = 16'hFFFF; start4 = 1'b1;
    @(negedge clk);
    tt_we4 = 1'b0; start4 = 1'b0;
    guard = 0;
    while (ox4 != 4'd8 && guard < 40) begin @(negedge clk); guard++; end
    if (guard >= 40) chk("reset_wait_timeout", 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    tt_m4 = INIT4; ones_m4 = 0; ones_m3 = 0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_no_done", done4, 0);
      chk("post_reset_idle", v4, 0);
    end
    sweep(1'b0, 16'h0, 1'b0, 1'b0, -1, 0, 1'b0, -1);

    // N=3 instance: F0 -> 4 ones, done in cycle 9
    sweep(1'b1, 16'h00F0, 1'b1, 1'b0, -1, 0, 1'b0, -1);
    chk("ones3_f0", ones3, 4);

    // Randomized evaluations and sweeps with random back-pressure
    for (int i = 0; i < 6; i++) begin
      rt = 16'($urandom);
      eval4(4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1), rt,
            int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 4; i++) begin
      rt = 16'($urandom);
      sweep(1'b0, rt, 1'b1, 1'b0, -1, 0, 1'b1, -1);
      sweep(1'b1, rt, 1'b1, 1'b0, -1, 0, 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_sweep_eval.md
Name: lut_sweep_eval

Overview:
Parametrised, clocked successor to our fixed 4-input switch-level function blocks. Holds an N-input boolean function as a loadable truth table and runs it in one of two modes: a single registered evaluation, or a hardware sweep of all 2^N input vectors. The sweep streams (x, y) pairs over a valid/ready interface and counts the ones. It replaces the bench-side exhaustive loop and sits between the stimulus generator and the result checker/logger.

Parameters:
N, 4, number of function inputs (1..8)
INIT_TT, {2**N{1'b0}}, truth table after reset; bit i = f(x=i)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
tt_we  input  1  truth-table write strobe
tt_wdata  input  2**N  new truth table
x  input  N  operand for single evaluation
eval_req  input  1  request single evaluation of x
start  input  1  request full sweep
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts beat
out_x  output  N  input vector of current beat
out_y  output  1  f(out_x)
out_last  output  1  final beat of the operation
busy  output  1  operation in progress
ones_cnt  output  N+1  number of y=1 beats in last completed sweep
done  output  1  one-cycle pulse after final sweep handshake

Behaviour:
- Clock/reset: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset: all outputs 0 (out_valid, out_x, out_y, out_last, busy, ones_cnt, done); tt = INIT_TT; state IDLE. Takes effect immediately, including mid-operation: sweep aborted, no done, ones_cnt cleared.
- States: IDLE, EVAL, SWEEP.
- IDLE: busy=0, out_valid=0.
  - start=1 -> SWEEP; idx=0; ones_cnt=0.
  - else eval_req=1 -> EVAL; x captured.
  - start and eval_req together: start wins, eval_req dropped.
- tt_we: table written at clock edge only when in IDLE; ignored while busy (table frozen). tt_we with start or eval_req in the same cycle: write applies, and the operation uses the new table.
- EVAL: out_valid=1, out_x=captured x, out_y=tt[x], out_last=1. Held stable until out_valid&out_ready, then -> IDLE. ones_cnt untouched. Latency: request edge -> beat valid the next cycle.
- SWEEP: out_valid=1, out_x=idx, out_y=tt[idx], out_last=(idx==2**N-1).
  - On handshake: ones_cnt += out_y.
  - idx < 2**N-1: idx++.
  - idx == 2**N-1: -> IDLE; done=1 for exactly the following cycle.
- busy=1 in EVAL and SWEEP.
- out_ready low: out_x, out_y, out_last held stable, no state change. Beats never dropped.
- Throughput: one beat per cycle with out_ready high. A sweep is 2**N beats; done arrives 2**N+1 cycles after the start edge.
- start and eval_req ignored while busy. In the done cycle state is IDLE, so a new start is accepted there.
- ones_cnt is valid from the done cycle and held until the next start or reset. Width N+1 holds 2**N without overflow; idx wraps only via the final-beat rule.

Test Plan:
- N=4, load tt=16'h8001, start at edge 0, out_ready=1 -> beats in cycles 1..16 with out_x=0..15; out_y=1 only for x=0,15; out_last only on x=15; done high in cycle 17; ones_cnt=2; busy low in cycle 17.
- Same sweep, out_ready=0 for 3 cycles while out_x=5 -> out_x/out_y/out_last stable during stall; done in cycle 20; ones_cnt=2.
- tt=16'hAAAA, x=7, eval_req -> next cycle out_valid=1, out_x=7, out_y=1, out_last=1; ones_cnt keeps its prior value; no done pulse.
- tt=16'h0000, sweep with tt_we=1/tt_wdata=16'hFFFF at beat 4 -> write ignored; ones_cnt=0; after done, a new sweep still gives 0. start+eval_req in the same cycle -> sweep runs.
- rst_n low asynchronously at beat 8 -> all outputs 0 at once; tt=INIT_TT; no done; next start sweeps from x=0.
- N=3, tt=8'hF0 -> 8 beats; out_y=1 for x=4..7; ones_cnt=4; done in cycle 9.
